out_capture: RTL

Wide-word capture FIFO that sits directly upstream of the 32-bit word-serializing read register. It accepts C_NUM_BITS-wide samples from a valid/ready producer and buffers up to C_DEPTH of them. It holds the head sample stable on `dout`, which feeds the serializer's `din`, until the serializer's end-of-word-sequence `read` pulse pops it. Software sees `avail`, `level` and `overflow_count` as status.

---
 rtl/out_capture.sv | 138 +++++++++++++
 1 files changed

// File: rtl/out_capture.sv
// ---------------------------------------------------------------------------
// out_capture
//   Capture FIFO for wide samples. It sits in front of the 32-bit
//   word-serializing read register. Samples arrive from a valid/ready
//   producer. The head sample is held steady on dout until the
//   serializer's end-of-sequence read pulse pops it.
//
// Parameters
//   C_NUM_BITS  sample width (1..1024)
//   C_DEPTH     FIFO entries, power of two (2..16)
//   C_DROP      0 = backpressure on s_ready, 1 = always ready, drop when full
//
// Ports
//   clk             rising-edge clock
//   resetn          synchronous active-low reset
//   s_data          producer sample
//   s_valid         producer sample valid
//   s_ready         accept indication (registered terms only)
//   dout            head sample, drives serializer din
//   read            one-cycle pop pulse from the serializer
//   avail           FIFO non-empty
//   level           stored entry count, 0..C_DEPTH
//   overflow_count  dropped samples (C_DROP=1), saturating
// ---------------------------------------------------------------------------
module out_capture #(
    parameter int C_NUM_BITS = 32,
    parameter int C_DEPTH    = 2,
    parameter int C_DROP     = 0
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [C_NUM_BITS-1:0]     s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic [C_NUM_BITS-1:0]     dout,
    input  logic                      read,
    output logic                      avail,
    output logic [$clog2(C_DEPTH):0]  level,
    output logic [15:0]               overflow_count
);

    localparam int PW = $clog2(C_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] C_FULL = LW'(C_DEPTH);

    logic [C_NUM_BITS-1:0] r_mem [0:C_DEPTH-1];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic [15:0]           r_ovf;
    logic [C_NUM_BITS-1:0] r_dout;
    logic                  r_rst_done;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_ready;
    logic [PW-1:0]         w_rd_next;

    assign w_full    = (r_level == C_FULL);
    assign w_empty   = (r_level == '0);
    assign w_pop     = read & ~w_empty;
    assign w_rd_next = r_rd_ptr + PW'(1);

    // s_ready depends only on registered state. In drop mode a full FIFO
    // can still take a sample when the head is popped on the same edge.
    always_comb begin
        w_ready = 1'b0;
        w_push  = 1'b0;
        w_drop  = 1'b0;
        if (C_DROP != 0) begin
            w_ready = r_rst_done;
            w_push  = s_valid & r_rst_done & (~w_full | w_pop);
            w_drop  = s_valid & r_rst_done & w_full & ~w_pop;
        end else begin
            w_ready = r_rst_done & ~w_full;
            w_push  = s_valid & w_ready;
        end
    end

    // Sample storage needs no reset; the entries are only read once valid.
    always_ff @(posedge clk) begin
        if (resetn && w_push) begin
            r_mem[r_wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_ovf      <= '0;
            r_dout     <= '0;
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end

            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase

            if (w_drop && (r_ovf != 16'hFFFF)) begin
                r_ovf <= r_ovf + 16'd1;
            end

            // dout is a copy of the head entry. It changes only when the head
            // changes, and it keeps the last popped sample once the FIFO drains.
            if (w_pop) begin
                if (r_level > LW'(1)) begin
                    r_dout <= r_mem[w_rd_next];
                end else if (w_push) begin
                    r_dout <= s_data;
                end
            end else if (w_push && w_empty) begin
                r_dout <= s_data;
            end
        end
    end

    assign s_ready        = w_ready;
    assign dout           = r_dout;
    assign avail          = ~w_empty;
    assign level          = r_level;
    assign overflow_count = r_ovf;

endmodule
